// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - fixed-priority arbiter sharing one async 16-bit SRAM between audio reads and a host port
//
// Purpose: sequences every SRAM access (IDLE -> ACCESS -> COMPLETE), drives the
// registered SRAM strobes and data-bus enable, and returns read data with a
// one-cycle completion pulse. Audio requests always win over the host.
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   aud_req, aud_addr          audio read request pulse and address
//   aud_data, aud_valid        last audio word and its update pulse
//   aud_overrun                sticky: audio request arrived while one was pending
//   host_req/we/addr/wdata     host level request, direction, address, write data
//   host_rdata, host_done      host read data and completion pulse
//   sram_addr, sram_dq_out     registered SRAM address and write data
//   sram_dq_oe, sram_dq_in     bus drive enable and bus read value
//   sram_*_n                   registered active-low SRAM strobes
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int ADDR_W        = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              aud_req,
  input  logic [ADDR_W-1:0] aud_addr,
  output logic [15:0]       aud_data,
  output logic              aud_valid,
  output logic              aud_overrun,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [15:0]       host_wdata,
  output logic [15:0]       host_rdata,
  output logic              host_done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ACCESS   = 2'd1;
  localparam logic [1:0] ST_COMPLETE = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              gnt_aud_q, gnt_aud_d;
  logic              gnt_we_q, gnt_we_d;
  logic              aud_pending_q, aud_pending_d;
  logic [ADDR_W-1:0] aud_addr_q, aud_addr_d;
  logic              aud_overrun_q, aud_overrun_d;
  logic [15:0]       aud_data_q, aud_data_d;
  logic [15:0]       host_rdata_q, host_rdata_d;
  logic              aud_valid_q, aud_valid_d;
  logic              host_done_q, host_done_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [15:0]       dq_out_q, dq_out_d;
  logic              dq_oe_q, dq_oe_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              grant_aud;

  // Strobes are registered, so they are computed from the state being entered.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    gnt_aud_d     = gnt_aud_q;
    gnt_we_d      = gnt_we_q;
    aud_pending_d = aud_pending_q;
    aud_addr_d    = aud_addr_q;
    aud_overrun_d = aud_overrun_q;
    aud_data_d    = aud_data_q;
    host_rdata_d  = host_rdata_q;
    aud_valid_d   = 1'b0;
    host_done_d   = 1'b0;
    sram_addr_d   = sram_addr_q;
    dq_out_d      = dq_out_q;
    dq_oe_d       = dq_oe_q;
    ce_n_d        = ce_n_q;
    oe_n_d        = oe_n_q;
    we_n_d        = we_n_q;
    grant_aud     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (aud_pending_q) begin
          state_d     = ST_ACCESS;
          cnt_d       = CNT_INIT;
          gnt_aud_d   = 1'b1;
          gnt_we_d    = 1'b0;
          grant_aud   = 1'b1;
          sram_addr_d = aud_addr_q;
          ce_n_d      = 1'b0;
          oe_n_d      = 1'b0;
          we_n_d      = 1'b1;
          dq_oe_d     = 1'b0;
        end else if (host_req) begin
          state_d     = ST_ACCESS;
          cnt_d       = CNT_INIT;
          gnt_aud_d   = 1'b0;
          gnt_we_d    = host_we;
          sram_addr_d = host_addr;
          ce_n_d      = 1'b0;
          oe_n_d      = host_we;
          we_n_d      = ~host_we;
          dq_oe_d     = host_we;
          if (host_we) begin
            dq_out_d = host_wdata;
          end
        end else begin
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          dq_oe_d = 1'b0;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d     = ST_COMPLETE;
          ce_n_d      = 1'b1;
          oe_n_d      = 1'b1;
          we_n_d      = 1'b1;
          // Keep driving write data one cycle past WE rising for hold time.
          dq_oe_d     = gnt_we_q;
          aud_valid_d = gnt_aud_q;
          host_done_d = ~gnt_aud_q;
          if (gnt_aud_q) begin
            aud_data_d = sram_dq_in;
          end else if (!gnt_we_q) begin
            host_rdata_d = sram_dq_in;
          end
        end else begin
          cnt_d = 4'(cnt_q - 4'd1);
        end
      end
      ST_COMPLETE: begin
        state_d = ST_IDLE;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        dq_oe_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        dq_oe_d = 1'b0;
      end
    endcase

    // A request in the grant cycle re-arms pending rather than counting as overrun.
    if (aud_req) begin
      aud_pending_d = 1'b1;
      aud_addr_d    = aud_addr;
      if (aud_pending_q && !grant_aud) begin
        aud_overrun_d = 1'b1;
      end
    end else if (grant_aud) begin
      aud_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 4'd0;
      gnt_aud_q     <= 1'b0;
      gnt_we_q      <= 1'b0;
      aud_pending_q <= 1'b0;
      aud_addr_q    <= '0;
      aud_overrun_q <= 1'b0;
      aud_data_q    <= 16'h0000;
      host_rdata_q  <= 16'h0000;
      aud_valid_q   <= 1'b0;
      host_done_q   <= 1'b0;
      sram_addr_q   <= '0;
      dq_out_q      <= 16'h0000;
      dq_oe_q       <= 1'b0;
      ce_n_q        <= 1'b1;
      oe_n_q        <= 1'b1;
      we_n_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      gnt_aud_q     <= gnt_aud_d;
      gnt_we_q      <= gnt_we_d;
      aud_pending_q <= aud_pending_d;
      aud_addr_q    <= aud_addr_d;
      aud_overrun_q <= aud_overrun_d;
      aud_data_q    <= aud_data_d;
      host_rdata_q  <= host_rdata_d;
      aud_valid_q   <= aud_valid_d;
      host_done_q   <= host_done_d;
      sram_addr_q   <= sram_addr_d;
      dq_out_q      <= dq_out_d;
      dq_oe_q       <= dq_oe_d;
      ce_n_q        <= ce_n_d;
      oe_n_q        <= oe_n_d;
      we_n_q        <= we_n_d;
    end
  end

  assign aud_data    = aud_data_q;
  assign aud_valid   = aud_valid_q;
  assign aud_overrun = aud_overrun_q;
  assign host_rdata  = host_rdata_q;
  assign host_done   = host_done_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  // Always full 16-bit words, so byte lanes follow chip enable.
  assign sram_ub_n   = ce_n_q;
  assign sram_lb_n   = ce_n_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed, table-driven self-checking bench for sram_arbiter
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        aud_req;
  logic [19:0] aud_addr;
  logic [15:0] aud_data;
  logic        aud_valid;
  logic        aud_overrun;
  logic        host_req;
  logic        host_we;
  logic [19:0] host_addr;
  logic [15:0] host_wdata;
  logic [15:0] host_rdata;
  logic        host_done;
  logic [19:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  sram_arbiter #(.ACCESS_CYCLES(2), .ADDR_W(20)) dut (
    .clk(clk), .reset(reset),
    .aud_req(aud_req), .aud_addr(aud_addr), .aud_data(aud_data),
    .aud_valid(aud_valid), .aud_overrun(aud_overrun),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_done(host_done),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  always #5 clk = ~clk;

  // Small SRAM model: low 12 address bits select a word.
  logic [15:0] mem [0:4095];
  always @(posedge clk) begin
    if (reset) begin
      mem[12'h123] <= 16'hBEEF;
      mem[12'h200] <= 16'h1234;
    end else if (!sram_ce_n && !sram_we_n) begin
      mem[sram_addr[11:0]] <= sram_dq_out;
    end
  end
  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[11:0]] : 16'h0000;

  // Cycle monitor sampled on the falling edge.
  int          cyc_n = 0;
  int          av_cnt = 0, hd_cnt = 0, av_at = 0, hd_at = 0;
  logic [19:0] last_rd_addr = '0;
  always @(negedge clk) begin
    cyc_n <= cyc_n + 1;
    if (aud_valid) begin
      av_cnt <= av_cnt + 1;
      av_at  <= cyc_n + 1;
    end
    if (host_done) begin
      hd_cnt <= hd_cnt + 1;
      hd_at  <= cyc_n + 1;
    end
    if (!sram_ce_n && !sram_oe_n) last_rd_addr <= sram_addr;
  end

  // {ce,oe,we,ub,lb,dq_oe,aud_valid,host_done}, addr, dq_out, aud_data, host_rdata
  logic [75:0] obs;
  assign obs = {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe,
                aud_valid, host_done, sram_addr, sram_dq_out, aud_data, host_rdata};

  typedef struct {
    logic        ar;
    logic [19:0] aa;
    logic        hr;
    logic        hw;
    logic [19:0] ha;
    logic [15:0] hd;
    logic [7:0]  strb;
    logic [19:0] addr;
    logic [15:0] dqo;
    logic [15:0] ad;
    logic [15:0] hrd;
  } vec_t;

  vec_t tv [15];
  int   n_err = 0;
  int   n_chk = 0;

  function automatic vec_t mk(logic ar, logic [19:0] aa, logic hr, logic hw, logic [19:0] ha,
                              logic [15:0] hd, logic [7:0] strb, logic [19:0] addr,
                              logic [15:0] dqo, logic [15:0] ad, logic [15:0] hrd);
    vec_t v;
    v.ar = ar; v.aa = aa; v.hr = hr; v.hw = hw; v.ha = ha; v.hd = hd;
    v.strb = strb; v.addr = addr; v.dqo = dqo; v.ad = ad; v.hrd = hrd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    aud_req = 1'b0; aud_addr = '0; host_req = 1'b0; host_we = 1'b0;
    host_addr = '0; host_wdata = 16'h0000;
  endtask

  localparam logic [75:0] RST_OBS = {8'hF8, 20'h0, 16'h0, 16'h0, 16'h0};

  int c0, av0, hd0;

  initial begin
    // Strobe codes: F8 idle, 20 read access, 44 write access,
    // FA audio complete, F9 host read complete, FD host write complete.
    tv[0]  = mk(1, 20'h00123, 0, 0, 20'h0,     16'h0,    8'hF8, 20'h00000, 16'h0000, 16'h0000, 16'h0000);
    tv[1]  = mk(0, 20'h0,     0, 0, 20'h0,     16'h0,    8'hF8, 20'h00000, 16'h0000, 16'h0000, 16'h0000);
    tv[2]  = mk(0, 20'h0,     0, 0, 20'h0,     16'h0,    8'h20, 20'h00123, 16'h0000, 16'h0000, 16'h0000);
    tv[3]  = mk(0, 20'h0,     0, 0, 20'h0,     16'h0,    8'h20, 20'h00123, 16'h0000, 16'h0000, 16'h0000);
    tv[4]  = mk(0, 20'h0,     0, 0, 20'h0,     16'h0,    8'hFA, 20'h00123, 16'h0000, 16'hBEEF, 16'h0000);
    tv[5]  = mk(0, 20'h0,     1, 1, 20'h0FFFF, 16'hA5A5, 8'hF8, 20'h00123, 16'h0000, 16'hBEEF, 16'h0000);
    tv[6]  = mk(0, 20'h0,     1, 1, 20'h0FFFF, 16'hA5A5, 8'h44, 20'h0FFFF, 16'hA5A5, 16'hBEEF, 16'h0000);
    tv[7]  = mk(0, 20'h0,     1, 1, 20'h0FFFF, 16'hA5A5, 8'h44, 20'h0FFFF, 16'hA5A5, 16'hBEEF, 16'h0000);
    tv[8]  = mk(0, 20'h0,     1, 1, 20'h0FFFF, 16'hA5A5, 8'hFD, 20'h0FFFF, 16'hA5A5, 16'hBEEF, 16'h0000);
    tv[9]  = mk(0, 20'h0,     0, 0, 20'h0,     16'h0,    8'hF8, 20'h0FFFF, 16'hA5A5, 16'hBEEF, 16'h0000);
    tv[10] = mk(0, 20'h0,     1, 0, 20'h0FFFF, 16'h0,    8'hF8, 20'h0FFFF, 16'hA5A5, 16'hBEEF, 16'h0000);
    tv[11] = mk(0, 20'h0,     1, 0, 20'h0FFFF, 16'h0,    8'h20, 20'h0FFFF, 16'hA5A5, 16'hBEEF, 16'h0000);
    tv[12] = mk(0, 20'h0,     1, 0, 20'h0FFFF, 16'h0,    8'h20, 20'h0FFFF, 16'hA5A5, 16'hBEEF, 16'h0000);
    tv[13] = mk(0, 20'h0,     1, 0, 20'h0FFFF, 16'h0,    8'hF9, 20'h0FFFF, 16'hA5A5, 16'hBEEF, 16'hA5A5);
    tv[14] = mk(0, 20'h0,     0, 0, 20'h0,     16'h0,    8'hF8, 20'h0FFFF, 16'hA5A5, 16'hBEEF, 16'hA5A5);

    // Reset and reset values
    reset = 1'b1;
    idle_inputs();
    repeat (3) step();
    @(negedge clk);
    chk("reset_outputs", 80'(obs), 80'(RST_OBS));
    chk("reset_overrun", 80'(aud_overrun), 80'(0));

    // Idle 20 cycles: nothing moves
    step();
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("idle_%0d", k), 80'({obs, aud_overrun}), 80'({RST_OBS, 1'b0}));
      step();
    end

    // Table: audio read, host write, host read (one row per cycle)
    for (int i = 0; i < 15; i++) begin
      aud_req = tv[i].ar; aud_addr = tv[i].aa;
      host_req = tv[i].hr; host_we = tv[i].hw;
      host_addr = tv[i].ha; host_wdata = tv[i].hd;
      @(negedge clk);
      chk($sformatf("vec_%0d", i), 80'(obs),
          80'({tv[i].strb, tv[i].addr, tv[i].dqo, tv[i].ad, tv[i].hrd}));
      step();
    end
    idle_inputs();

    // Audio request in the grant cycle: re-latched, no overrun
    av0 = av_cnt;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step();
      if (k == 0) c0 = cyc_n + 1;
      aud_req  = (k == 0 || k == 1);
      aud_addr = (k == 0) ? 20'h00123 : 20'h00200;
      @(negedge clk);
    end
    #1;
    chk("grant_cycle_av_count", 80'(av_cnt - av0), 80'(2));
    chk("grant_cycle_av_at", 80'(av_at - c0), 80'(8));
    chk("grant_cycle_data", 80'(aud_data), 80'(16'h1234));
    chk("grant_cycle_no_overrun", 80'(aud_overrun), 80'(0));
    step();
    idle_inputs();

    // Tie: audio and host both seen in the same IDLE cycle after a COMPLETE
    av0 = av_cnt; hd0 = hd_cnt;
    for (int k = 0; k < 14; k++) begin
      if (k > 0) step();
      if (k == 0) c0 = cyc_n + 1;
      aud_req   = (k == 0 || k == 4);
      aud_addr  = (k == 0) ? 20'h00123 : 20'h00200;
      host_req  = (k >= 4 && k <= 12);
      host_we   = 1'b0;
      host_addr = 20'h0FFFF;
      @(negedge clk);
    end
    #1;
    chk("tie_av_count", 80'(av_cnt - av0), 80'(2));
    chk("tie_av_at", 80'(av_at - c0), 80'(8));
    chk("tie_hd_count", 80'(hd_cnt - hd0), 80'(1));
    chk("tie_hd_at", 80'(hd_at - c0), 80'(12));
    chk("tie_aud_data", 80'(aud_data), 80'(16'h1234));
    chk("tie_host_rdata", 80'(host_rdata), 80'(16'hA5A5));
    step();
    idle_inputs();

    // Overrun: two audio pulses during a host write; second address wins
    av0 = av_cnt; hd0 = hd_cnt;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step();
      if (k == 0) c0 = cyc_n + 1;
      host_req   = (k <= 3);
      host_we    = 1'b1;
      host_addr  = 20'h00300;
      host_wdata = 16'h5555;
      aud_req    = (k == 1 || k == 2);
      aud_addr   = (k == 1) ? 20'h00123 : 20'h00300;
      @(negedge clk);
    end
    #1;
    chk("ovr_hd_at", 80'(hd_at - c0), 80'(3));
    chk("ovr_av_count", 80'(av_cnt - av0), 80'(1));
    chk("ovr_av_at", 80'(av_at - c0), 80'(7));
    chk("ovr_addr_data", 80'({last_rd_addr, aud_data}), 80'({20'h00300, 16'h5555}));
    chk("ovr_sticky", 80'(aud_overrun), 80'(1));
    step();
    idle_inputs();
    repeat (5) step();
    @(negedge clk);
    chk("ovr_still_sticky", 80'(aud_overrun), 80'(1));
    step();

    // Reset in the second ACCESS cycle of a host write, audio pending
    av0 = av_cnt; hd0 = hd_cnt;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step();
      host_req   = (k <= 2);
      host_we    = 1'b1;
      host_addr  = 20'h00400;
      host_wdata = 16'h7777;
      aud_req    = (k == 1);
      aud_addr   = 20'h00123;
      reset      = (k == 2);
      @(negedge clk);
      if (k == 3) begin
        chk("rst_mid_outputs", 80'(obs), 80'(RST_OBS));
        chk("rst_mid_overrun", 80'(aud_overrun), 80'(0));
      end
    end
    #1;
    chk("rst_mid_no_done", 80'(hd_cnt - hd0), 80'(0));
    chk("rst_mid_pending_dropped", 80'(av_cnt - av0), 80'(0));
    step();
    idle_inputs();

    // Fresh audio read after abort: idle latency proves the FSM is in IDLE
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step();
      if (k == 0) c0 = cyc_n + 1;
      aud_req  = (k == 0);
      aud_addr = 20'h00123;
      @(negedge clk);
    end
    #1;
    chk("post_rst_av_at", 80'(av_at - c0), 80'(4));
    chk("post_rst_data", 80'(aud_data), 80'(16'hBEEF));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
